// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types: frame FSM states, prefix and
// protocol byte codes, Pause-sequence skip length.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_AA = 8'hAA;
  localparam logic [7:0] B_EE = 8'hEE;
  localparam logic [7:0] B_FE = 8'hFE;
  localparam logic [7:0] B_00 = 8'h00;
  localparam logic [7:0] B_FF = 8'hFF;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Keyboard replies (ack, BAT ok, echo, resend, errors)
  // that never map to a key event.
  function automatic logic is_ignored(
    input logic [7:0] b
  );
    return (b == B_FA) || (b == B_AA) ||
           (b == B_EE) || (b == B_FE) ||
           (b == B_00) || (b == B_FF);
  endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// PS/2 line conditioner: 2-flop sync on clock and data,
// glitch filter on clock, one-cycle pulse on filtered fall.
// Ports: clk_sys, reset_n, ps2_clk_i, ps2_data_i (raw lines);
//        clk_fall (filtered fall pulse), data_s (synced data).
module ps2_edge_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_fall,
  output logic data_s
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_f;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_f    <= 1'b1;
      cnt      <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_i};
      dat_sync <= {dat_sync[0], ps2_data_i};
      // cnt counts consecutive samples that disagree
      // with the accepted level; any agreeing sample
      // restarts the run.
      if (clk_sync[1] == clk_f) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        clk_f <= clk_sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign clk_fall = clk_f & ~clk_sync[1] &
                    (cnt == CNT_MAX);
  assign data_s   = dat_sync[1];

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver producing the 11-bit key event word
// {toggle, pressed, extended, code}; handles E0/F0/E1 prefixes.
// Ports: clk_sys, reset_n (async, active low), ps2_clk_i,
//   ps2_data_i (raw lines); ps2_key (event word), frame_err
//   (1-cycle error pulse), busy (frame in progress).
// Option: PS2_TYPEMATIC_FILTER_EN suppresses repeated makes.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 48_000_000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);

  localparam int TMO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW      = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LD = TW'(TMO_CYC - 1);

  state_t        state;
  state_t        state_n;
  logic          fall;
  logic          dat;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tmo;
  logic          tmo_exp;
  logic          err_n;
  logic          byte_ok;

  logic          ext;
  logic          brk;
  logic [2:0]    skip_cnt;
  logic          is_e0;
  logic          is_e1;
  logic          is_f0;
  logic          is_ign;
  logic          key_byte;
  logic          emit;

  ps2_edge_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filt (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_fall   (fall),
    .data_s     (dat)
  );

  // Edges and expiry are exclusive: an edge reloads
  // the counter in the same cycle.
  assign tmo_exp = (state != IDLE) && !fall &&
                   (tmo == '0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    byte_ok = 1'b0;
    if (tmo_exp) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          if (dat) err_n = 1'b1;
          else     state_n = DATA;
        end
        DATA: begin
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          // odd parity over 8 data bits + parity bit
          if (dat ^ (^shreg)) begin
            state_n = STOP;
          end else begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
        end
        STOP: begin
          state_n = IDLE;
          if (dat) byte_ok = 1'b1;
          else     err_n   = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      tmo       <= TMO_LD;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_n;
      if (state == IDLE || fall) tmo <= TMO_LD;
      else if (tmo != '0)        tmo <= tmo - TW'(1);
      if (tmo_exp) begin
        shreg <= '0;
      end else if (fall && state == IDLE) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (fall && state == DATA) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {dat, shreg[7:1]};
      end
    end
  end

  assign busy = (state != IDLE);

  assign is_e0    = (shreg == B_E0);
  assign is_e1    = (shreg == B_E1);
  assign is_f0    = (shreg == B_F0);
  assign is_ign   = is_ignored(shreg);
  assign key_byte = byte_ok && (skip_cnt == '0) &&
                    !is_e0 && !is_e1 && !is_f0 &&
                    !is_ign;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] last_make;

  // Cleared value {0,00} never matches: code 00 is
  // always dropped before reaching this compare.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      last_make <= '0;
    end else if (err_n) begin
      last_make <= '0;
    end else if (key_byte) begin
      if (!brk)
        last_make <= {ext, shreg};
      else if ({ext, shreg} == last_make)
        last_make <= '0;
    end
  end

  assign emit = brk | ({ext, shreg} != last_make);
`else
  assign emit = 1'b1;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_key  <= '0;
      ext      <= 1'b0;
      brk      <= 1'b0;
      skip_cnt <= '0;
    end else if (err_n) begin
      ext      <= 1'b0;
      brk      <= 1'b0;
      skip_cnt <= '0;
    end else if (byte_ok) begin
      if (skip_cnt != '0) begin
        skip_cnt <= skip_cnt - 3'd1;
      end else begin
        unique case (1'b1)
          is_e1:  skip_cnt <= PAUSE_SKIP;
          is_e0:  ext <= 1'b1;
          is_f0:  brk <= 1'b1;
          is_ign: begin end
          default: begin
            ext <= 1'b0;
            brk <= 1'b0;
            if (emit)
              ps2_key <= {~ps2_key[10], ~brk,
                          ext, shreg};
          end
        endcase
      end
    end
  end

endmodule
